// File: rtl/lsu_load_writeback_pkg.sv
// Shared core types for the LSU writeback path.
// Holds the wbPkt bundle and its field widths.
package lsu_load_writeback_pkg;

  localparam int SIZE_PHYSICAL_LOG   = 7;
  localparam int SIZE_DATA           = 32;
  localparam int SIZE_ACTIVELIST_LOG = 7;
  localparam int SIZE_LSQ_LOG        = 5;

  typedef struct packed {
    logic                           valid;
    logic [SIZE_PHYSICAL_LOG-1:0]   phyDest;
    logic [SIZE_DATA-1:0]           destData;
    logic [SIZE_ACTIVELIST_LOG-1:0] alID;
    logic [SIZE_LSQ_LOG-1:0]        lqID;
  } wbPkt;

endpackage

// File: rtl/lsu_load_writeback_miss.sv
// Miss fill buffer: DEPTH-entry FIFO of wbPkt.
// Ports: clk, clear_i, push_i, pop_i, data_i, data_o,
//        count_o, full_o, empty_o.
module lsu_miss_fifo
  import lsu_load_writeback_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  wbPkt                     data_i,
  output wbPkt                     data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  wbPkt             mem_q [DEPTH];

  logic do_push;
  logic do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[head_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (do_push) tail_d = tail_q + PTR_W'(1);
    if (do_pop)  head_d = head_q + PTR_W'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no clear: count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[tail_q] <= data_i;
  end

endmodule

// File: rtl/lsu_load_writeback.sv
// Load writeback merge: hits via 1-cycle register, misses via FIFO.
// Ports: clk, reset, flush_i, hitPacket_i, missPacket_i,
//        missReady_o, hitStall_o, wbPacket_o, protoErr_o.
module lsu_load_writeback
  import lsu_load_writeback_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic flush_i,
  input  wbPkt hitPacket_i,
  input  wbPkt missPacket_i,
  output logic missReady_o,
  output logic hitStall_o,
  output wbPkt wbPacket_o,
  output logic protoErr_o
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic                   clr;
  logic                   hit_v;
  logic                   deq;
  logic                   push;
  wbPkt                   head;
  logic [$clog2(DEPTH):0] miss_cnt;
  logic                   miss_full;
  logic                   miss_empty;

  wbPkt       wb_q, wb_d;
  logic [7:0] starve_q, starve_d;
  logic       stall_q, stall_d;
  logic       err_q, err_d;

  assign clr   = reset | flush_i;
  assign hit_v = hitPacket_i.valid;
  assign push  = missPacket_i.valid & ~miss_full;
  // A hit always wins, even one driven against hitStall_o.
  assign deq   = ~hit_v & ~miss_empty;

  lsu_miss_fifo #(
    .DEPTH (DEPTH)
  ) u_miss_fifo (
    .clk     (clk),
    .clear_i (clr),
    .push_i  (push),
    .pop_i   (deq),
    .data_i  (missPacket_i),
    .data_o  (head),
    .count_o (miss_cnt),
    .full_o  (miss_full),
    .empty_o (miss_empty)
  );

  always_comb begin
    wb_d     = '0;
    starve_d = starve_q;
    unique case (1'b1)
      hit_v:   wb_d = hitPacket_i;
      deq:     wb_d = head;
      default: wb_d = '0;
    endcase
    if (deq || miss_cnt == '0) begin
      starve_d = '0;
    end else if (hit_v && starve_q < LIMIT) begin
      starve_d = starve_q + 8'd1;
    end
    // Stall holds while saturated; any dequeue drops it.
    stall_d = (starve_d == LIMIT);
    err_d   = err_q | (hit_v & stall_q);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wb_q     <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      wb_q     <= wb_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
      err_q    <= err_d;
    end
  end

  assign wbPacket_o  = wb_q;
  assign hitStall_o  = stall_q;
  assign protoErr_o  = err_q;
  assign missReady_o = ~miss_full;

endmodule

// File: doc/lsu_load_writeback.md
# lsu_load_writeback

Return path from the load-store unit to the execute/bypass network: merges cache-hit load results and cache-miss fill returns onto the single load writeback port. Hits pass through a one-cycle pipeline register. Misses are buffered in a small FIFO and drained in cycles with no hit. A starvation counter throttles the hit path so buffered misses always make progress. The block sits between the LSU data-cache read/fill logic and the writeback-stage register file/bypass.

## Interface
- DEPTH, 4, miss FIFO entries; power of two, ≥2
- STARVE_LIMIT, 8, consecutive blocked cycles before the hit path is throttled; 1..255
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- flush_i  in  1  pipeline recovery flush; synchronous, same effect as reset on all state
- hitPacket_i  in  wbPkt  load-hit result; valid field qualifies; no backpressure
- missPacket_i  in  wbPkt  miss fill return; valid field qualifies
- missReady_o  out  1  FIFO can accept missPacket_i this cycle
- hitStall_o  out  1  LSU must not present a valid hitPacket_i this cycle
- wbPacket_o  out  wbPkt  registered writeback packet to register file/bypass
- protoErr_o  out  1  sticky; hit presented while hitStall_o high

## Operation
- wbPkt fields: valid, phyDest, destData, alID, lqID.
- Enqueue: missPacket_i.valid && missReady_o writes the tail and advances the tail pointer. missPacket_i.valid with missReady_o low is ignored; the sender holds the packet until ready.
- missReady_o = (count != DEPTH), decoded from the registered count. A same-cycle dequeue gives no credit, so a full FIFO refuses enqueue even while draining.
- Output select each cycle:
  - If hitPacket_i.valid, the hit is selected.
  - Otherwise, if count != 0, the FIFO head is selected and dequeued.
  - Otherwise nothing is selected.
- wbPacket_o loads the selected packet at the clock edge. With nothing selected, wbPacket_o loads all zeros (valid = 0).
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance. An empty FIFO never dequeues in the cycle it is written; there is no fall-through.
- Pointers are log2(DEPTH) bits and wrap naturally.
- count is log2(DEPTH)+1 bits and ranges 0..DEPTH.
- Starvation counter starveCnt, 8 bits:
  - Increments when count != 0 and hitPacket_i.valid (head blocked).
  - Clears on any dequeue or when count == 0.
  - Saturates at STARVE_LIMIT.
- hitStall_o is registered: it goes high the cycle after starveCnt reaches STARVE_LIMIT.
  - While high, the head dequeues (the hit is absent) and starveCnt clears.
  - hitStall_o therefore drops after exactly one cycle.
- Protocol violation: hitPacket_i.valid while hitStall_o is high.
  - The hit still wins; the miss head is not dequeued.
  - protoErr_o sets and stays set until reset/flush.
  - hitStall_o stays high until a dequeue occurs.
- Reset/flush: wbPacket_o = 0, count = 0, pointers = 0, starveCnt = 0, hitStall_o = 0, protoErr_o = 0, missReady_o = 1. A miss presented in the flush cycle is dropped.

## Timing
- Hit latency: 1 cycle (hit valid in cycle N → wbPacket_o valid in cycle N+1).
- Miss latency: minimum 2 cycles (accepted in N, head visible in N+1, wbPacket_o valid in N+2 if no hit in N+1).
- Throughput: one writeback per cycle. Sustained miss acceptance is one per cycle only while no hits occur.
- Worst-case miss wait behind continuous hits: STARVE_LIMIT+1 cycles per entry.
- All outputs are registered or decoded from registers only; no combinational path from any input to any output.

## Structure
- Shared package (existing core package):
  - wbPkt struct.
  - Width constants SIZE_PHYSICAL_LOG, SIZE_DATA, SIZE_ACTIVELIST_LOG, SIZE_LSQ_LOG.
- Miss buffer is a natural sub-module, lsu_miss_fifo.
  - Ports: push, pop, data in/out, count, full, empty; synchronous clear on reset|flush.
- The top level holds the select mux, output register, starvation counter and hitStall_o/protoErr_o logic.

## Test plan
- Isolated hit: hit phyDest=5, destData=0xDEAD in cycle 3 → wbPacket_o.valid=1, phyDest=5 in cycle 4; valid=0 in cycle 5.
- Lone miss: miss lqID=2 in cycle 3 (no hits) → wbPacket_o carries lqID=2 in cycle 5; count returns to 0.
- Fill to full: 4 misses in cycles 1-4 under continuous hits → missReady_o low from cycle 5; a 5th miss is held by the sender and not lost; all 5 eventually drain in order.
- Starvation: 1 miss queued, hits every cycle, STARVE_LIMIT=8 → hitStall_o high for exactly one cycle; the miss appears on wbPacket_o in the following cycle; hits resume; protoErr_o stays 0.
- Violation: hit driven while hitStall_o is high → the hit is written back, protoErr_o=1 (sticky), hitStall_o is held until the next dequeue.
- Flush mid-drain: 3 misses queued, flush_i in cycle 10 → cycle 11: wbPacket_o.valid=0, missReady_o=1, hitStall_o=0; no stale miss is ever emitted.
